csa_select_pipe: RTL and testbench

CSA_SELECT_PIPE -- requirements
Module: csa_select_pipe

---
 rtl/csa_select_pipe_pkg.sv | 18 +
 rtl/csa_group_select.sv | 17 +
 rtl/csa_select_pipe.sv | 123 ++++++++++++
 tb/tb_csa_select_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_select_pipe_pkg.sv
// Shared conditional-sum definitions: group width, default group count, counter width,
// and the per-group result bundle used by the selection ripple.
`default_nettype none

package csa_select_pipe_pkg;

  localparam int CSA_GROUPS_DEFAULT = 4;
  localparam int CSA_GROUP_W        = 2;
  localparam int CSA_OPCNT_W        = 16;

  typedef struct packed {
    logic                   cout;
    logic [CSA_GROUP_W-1:0] sum;
  } grp_res_t;

endpackage

`default_nettype wire

// File: rtl/csa_group_select.sv
// One conditional-sum group: picks the carry-in=1 or carry-in=0 candidate {cout, sum}.
`default_nettype none

module csa_group_select
  import csa_select_pipe_pkg::*;
(
  input  logic     i_carry,
  input  grp_res_t i_c1,
  input  grp_res_t i_c0,
  output grp_res_t o_res
);

  assign o_res = i_carry ? i_c1 : i_c0;

endmodule

`default_nettype wire

// File: rtl/csa_select_pipe.sv
// Two-stage carry-select adder pipeline: stage 1 captures candidate sets, stage 2 ripples
// the group carry through the selectors and registers the result; valid/ready on both sides.
`default_nettype none

module csa_select_pipe
  import csa_select_pipe_pkg::*;
#(
  parameter  int GROUPS = CSA_GROUPS_DEFAULT,
  localparam int W      = CSA_GROUP_W * GROUPS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cin,
  input  logic [W-1:0]           c1_sum,
  input  logic [GROUPS-1:0]      c1_cout,
  input  logic [W-1:0]           c0_sum,
  input  logic [GROUPS-1:0]      c0_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           sum,
  output logic                   cout,
  output logic [CSA_OPCNT_W-1:0] op_count
);

  logic                   r_s1_valid;
  logic                   r_s1_cin;
  logic [W-1:0]           r_s1_c1_sum;
  logic [GROUPS-1:0]      r_s1_c1_cout;
  logic [W-1:0]           r_s1_c0_sum;
  logic [GROUPS-1:0]      r_s1_c0_cout;

  logic                   r_out_valid;
  logic [W-1:0]           r_sum;
  logic                   r_cout;
  logic [CSA_OPCNT_W-1:0] r_op_count;

  logic                   w_s2_load;
  logic                   w_s1_adv;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [GROUPS:0]        w_carry;
  logic [W-1:0]           w_sel_sum;

  // Ready depends only on registered state and out_ready, never on in_* inputs.
  assign w_s2_load  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  assign w_carry[0] = r_s1_cin;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    grp_res_t w_c1;
    grp_res_t w_c0;
    grp_res_t w_res;

    assign w_c1 = '{cout: r_s1_c1_cout[g], sum: r_s1_c1_sum[CSA_GROUP_W*g +: CSA_GROUP_W]};
    assign w_c0 = '{cout: r_s1_c0_cout[g], sum: r_s1_c0_sum[CSA_GROUP_W*g +: CSA_GROUP_W]};

    csa_group_select u_sel (
      .i_carry (w_carry[g]),
      .i_c1    (w_c1),
      .i_c0    (w_c0),
      .o_res   (w_res)
    );

    assign w_carry[g+1]                             = w_res.cout;
    assign w_sel_sum[CSA_GROUP_W*g +: CSA_GROUP_W] = w_res.sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_cin     <= 1'b0;
      r_s1_c1_sum  <= '0;
      r_s1_c1_cout <= '0;
      r_s1_c0_sum  <= '0;
      r_s1_c0_cout <= '0;
    end else if (w_in_fire) begin
      r_s1_valid   <= 1'b1;
      r_s1_cin     <= cin;
      r_s1_c1_sum  <= c1_sum;
      r_s1_c1_cout <= c1_cout;
      r_s1_c0_sum  <= c0_sum;
      r_s1_c0_cout <= c0_cout;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_sel_sum;
      r_cout      <= w_carry[GROUPS];
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_fire) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_csa_select_pipe.sv
// Bench for csa_select_pipe: directed literal cases plus random traffic against an
// in-order queue model of the two-deep pipeline, finishing with a 65536-transfer run.
`default_nettype none

module tb_csa_select_pipe;

  localparam int G = 4;
  localparam int W = 2 * G;
  localparam int TOTAL = 65536;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          cin;
  logic [W-1:0]  c1_sum;
  logic [G-1:0]  c1_cout;
  logic [W-1:0]  c0_sum;
  logic [G-1:0]  c0_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic [15:0]   op_count;

  csa_select_pipe #(.GROUPS(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .c1_sum    (c1_sum),
    .c1_cout   (c1_cout),
    .c0_sum    (c0_sum),
    .c0_cout   (c0_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Operands currently on the input bus; the model adds them directly.
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [2:0] t0;
    logic [2:0] t1;
    cur_a = a;
    cur_b = b;
    cin   = ci;
    for (int g = 0; g < G; g++) begin
      t0 = {1'b0, a[2*g +: 2]} + {1'b0, b[2*g +: 2]};
      t1 = t0 + 3'd1;
      c0_sum[2*g +: 2] = t0[1:0];
      c0_cout[g]       = t0[2];
      c1_sum[2*g +: 2] = t1[1:0];
      c1_cout[g]       = t1[2];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: in-order queue of results; "vis" marks the one currently in the output register.
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         vis;
  } ent_t;

  ent_t q[$];
  int   m_count = 0;
  int   m_acc   = 0;

  always @(negedge clk) begin
    logic   exp_vis;
    logic   pend;
    logic   exp_ir;
    logic [W:0] tot;
    ent_t   e;
    if (rst) begin
      q.delete();
      m_count = 0;
      m_acc   = 0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
    end else begin
      exp_vis = (q.size() > 0) && q[0].vis;
      pend    = (q.size() > 0 && !q[0].vis) || (q.size() > 1);
      exp_ir  = !pend || !exp_vis || out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vis});
      if (exp_vis) begin
        chk("sum", {24'd0, sum}, {24'd0, q[0].s});
        chk("cout", {31'd0, cout}, {31'd0, q[0].c});
      end
      chk("op_count", {16'd0, op_count}, m_count & 32'hFFFF);
      if (exp_vis && out_ready) begin
        void'(q.pop_front());
        m_count++;
      end
      if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
      if (in_valid && exp_ir) begin
        tot   = {1'b0, cur_a} + {1'b0, cur_b} + {{W{1'b0}}, cin};
        e.s   = tot[W-1:0];
        e.c   = tot[W];
        e.vis = 1'b0;
        q.push_back(e);
        m_acc++;
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Literal single-set latency check: out_valid must appear exactly after edge N+1.
  task automatic one_shot(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic ec, input string name);
    drive(a, b, ci);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
    step();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) step();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    one_shot(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
    one_shot(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    one_shot(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "add_ff_00_c");

    // Backpressure: two sets taken, then stall with the first result held.
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 1'b0);
    in_valid = 1'b1;
    step();
    drive(8'h33, 8'h44, 1'b1);
    step();
    drive(8'h55, 8'h66, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_sum", {24'd0, sum}, 32'h33);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_second", {24'd0, sum}, 32'h78);
    step();
    chk("bp_third", {24'd0, sum}, 32'hBB);
    step();

    // Reset with both stages full.
    out_ready = 1'b0;
    drive(8'hAA, 8'h11, 1'b0);
    in_valid = 1'b1;
    step();
    drive(8'h0F, 8'hF0, 1'b1);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {24'd0, sum}, 32'd0);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    step();
    rst = 1'b0;
    step();
    drive(8'h12, 8'h34, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_sum", {24'd0, sum}, 32'h47);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

    // Random traffic with backpressure, then full rate until TOTAL transfers since reset.
    for (int i = 0; i < 3000; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom));
      in_valid  = (($urandom % 4) != 0) && (m_acc < TOTAL);
      out_ready = ($urandom % 4) != 0;
      step();
    end
    guard = 0;
    while (m_count < TOTAL && guard < 80000) begin
      drive(W'($urandom), W'($urandom), 1'($urandom));
      in_valid  = (m_acc < TOTAL);
      out_ready = 1'b1;
      step();
      guard++;
    end
    if (m_count < TOTAL) chk("drain_timeout", m_count, TOTAL);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("wrap_op_count", {16'd0, op_count}, 32'd0);
    chk("end_out_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
